// File: rtl/operand_entry_ctrl.sv
// operand_entry_ctrl: operand-entry front end for the 7-bit ripple-carry adder.
// Synchronises the switch bus and four pushbuttons, debounces the buttons,
// turns each debounced press into a one-cycle load strobe, assembles operands
// A and B from nibble loads and offers them to the adder with valid/ack.
// Optional build macro: DEBOUNCE_BYPASS_EN (debounce counters removed, d = s).
module operand_entry_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 250000,
  parameter int unsigned CNT_W           = 18
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] y,
  input  logic       pb1,
  input  logic       pb2,
  input  logic       pb3,
  input  logic       pb4,
  output logic [6:0] a,
  output logic [6:0] b,
  output logic       operands_valid,
  input  logic       operands_ack,
  output logic [3:0] loaded
);

  typedef enum logic {COLLECT, READY} state_t;

  logic [3:0] pb_raw;
  logic [3:0] pb_meta, pb_s;
  logic [3:0] y_meta, y_s;
  logic [1:0] fill;
  logic       filled;
  logic [3:0] d;          // debounced level per button
  logic [3:0] armed;      // button has been seen released (debounced) since reset
  logic [3:0] lvl, lvl_prev;
  logic [3:0] strobe;
  logic       ack_take;
  state_t     state_q, state_d;

  assign pb_raw = {pb4, pb3, pb2, pb1};
  // The synchronisers hold reset zeros for two edges; those are not real samples.
  assign filled = (fill == 2'd2);

  // Two-flop synchronisers for the switch bus and buttons, plus fill tracker.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_meta  <= '0;
      y_s     <= '0;
      pb_meta <= '0;
      pb_s    <= '0;
      fill    <= '0;
    end else begin
      y_meta  <= y;
      y_s     <= y_meta;
      pb_meta <= pb_raw;
      pb_s    <= pb_meta;
      if (!filled) fill <= fill + 2'd1;
    end
  end

`ifdef DEBOUNCE_BYPASS_EN
  // Bypass build: level follows the synchroniser; arm once a real low is seen.
  assign d = pb_s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      armed <= '0;
    end else begin
      for (int i = 0; i < 4; i++)
        if (filled && !pb_s[i]) armed[i] <= 1'b1;
    end
  end
`else
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [3:0][CNT_W-1:0] cnt;

  // Per-button debounce. Until armed, the button is treated as debounced-high,
  // so a press held through reset must first be debounced low before it counts.
  // NOTE: the counter array is small and control-critical, so it is reset like any other flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      d     <= '0;
      armed <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (!filled || (pb_s[i] == (d[i] | ~armed[i]))) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_LAST) begin
          cnt[i] <= '0;
          if (armed[i]) d[i] <= pb_s[i];
          else          armed[i] <= 1'b1;
        end else begin
          cnt[i] <= cnt[i] + CNT_W'(1);
        end
      end
    end
  end
`endif

  assign lvl = d & armed;

  // Registered rising-edge detector: one strobe per accepted press.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lvl_prev <= '0;
      strobe   <= '0;
    end else begin
      lvl_prev <= lvl;
      strobe   <= lvl & ~lvl_prev;
    end
  end

  assign ack_take = operands_valid && operands_ack;

  // Field capture and loaded flags; a strobe in the ack cycle survives the clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a      <= '0;
      b      <= '0;
      loaded <= '0;
    end else begin
      if (strobe[0]) a[3:0] <= y_s;
      if (strobe[1]) a[6:4] <= y_s[2:0];
      if (strobe[2]) b[3:0] <= y_s;
      if (strobe[3]) b[6:4] <= y_s[2:0];
      loaded <= (ack_take ? 4'b0000 : loaded) | strobe;
    end
  end

  // Handshake state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= COLLECT;
    else        state_q <= state_d;
  end

  // Next state: ready once every nibble is loaded, back to collecting on ack.
  // NOTE: default assignment first so no path leaves state_d unassigned (no latch).
  always_comb begin
    state_d = state_q;
    case (state_q)
      COLLECT: if (loaded == 4'b1111) state_d = READY;
      READY:   if (operands_ack)      state_d = COLLECT;
      default: state_d = COLLECT;
    endcase
  end

  // Output decode: valid is the registered READY state.
  always_comb begin
    operands_valid = (state_q == READY);
  end

endmodule

// File: tb/tb_operand_entry_ctrl.sv
// Bench for operand_entry_ctrl with a short debounce window. Directed scenarios
// check fixed expected values; a randomized phase compares every cycle against
// a behavioural model built from run lengths of synchronised samples.
module tb_operand_entry_ctrl;

  localparam int DC = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] y;
  logic       pb1, pb2, pb3, pb4;
  logic       operands_ack;
  logic [6:0] a, b;
  logic       operands_valid;
  logic [3:0] loaded;

  int n_checks = 0;
  int n_pass   = 0;

  operand_entry_ctrl #(.DEBOUNCE_CYCLES(DC), .CNT_W(3)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .y              (y),
    .pb1            (pb1),
    .pb2            (pb2),
    .pb3            (pb3),
    .pb4            (pb4),
    .a              (a),
    .b              (b),
    .operands_valid (operands_valid),
    .operands_ack   (operands_ack),
    .loaded         (loaded)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural reference model ----------------
  logic [3:0] m_p1, m_p2, m_y1, m_y2;   // raw samples one / two edges old
  logic       m_v1, m_v2;               // sample is a real post-reset sample
  int         run_len [4];
  logic [3:0] run_val, m_deb, m_armed;
  int         cap_cd  [4];
  logic [6:0] m_a, m_b;
  logic [3:0] m_loaded;
  logic       m_valid;

  task automatic model_reset();
    m_p1 = '0; m_p2 = '0; m_y1 = '0; m_y2 = '0; m_v1 = 1'b0; m_v2 = 1'b0;
    run_val = '0; m_deb = '0; m_armed = '0;
    for (int i = 0; i < 4; i++) begin run_len[i] = 0; cap_cd[i] = 0; end
    m_a = '0; m_b = '0; m_loaded = '0; m_valid = 1'b0;
  endtask

  // One rising edge. A level is accepted once DC consecutive real samples
  // disagree with it; an accepted rise is captured two edges later.
  task automatic model_step();
    logic [3:0] s, ys, cap;
    logic take, nvalid;
    if (!rst_n) begin model_reset(); return; end
    s = m_p2; ys = m_y2; cap = '0;
    for (int i = 0; i < 4; i++) begin
      if (cap_cd[i] == 1) cap[i] = 1'b1;
      if (cap_cd[i] > 0) cap_cd[i]--;
      if (!m_v2) run_len[i] = 0;
      else begin
        if (run_len[i] > 0 && run_val[i] == s[i]) run_len[i]++;
        else begin run_val[i] = s[i]; run_len[i] = 1; end
        if (run_len[i] >= DC) begin
          if (!m_armed[i]) begin
            if (!run_val[i]) m_armed[i] = 1'b1;
          end else if (run_val[i] != m_deb[i]) begin
            m_deb[i] = run_val[i];
            if (run_val[i]) cap_cd[i] = 2;
          end
        end
      end
    end
    take = m_valid && operands_ack;
    if (cap[0]) m_a[3:0] = ys;
    if (cap[1]) m_a[6:4] = ys[2:0];
    if (cap[2]) m_b[3:0] = ys;
    if (cap[3]) m_b[6:4] = ys[2:0];
    nvalid   = take ? 1'b0 : (m_valid || (m_loaded == 4'b1111));
    m_loaded = (take ? 4'b0000 : m_loaded) | cap;
    m_valid  = nvalid;
    m_p2 = m_p1; m_v2 = m_v1; m_p1 = {pb4, pb3, pb2, pb1}; m_v1 = 1'b1;
    m_y2 = m_y1; m_y1 = y;
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic cycles(input int n);
    for (int k = 0; k < n; k++) cycle();
  endtask

  task automatic set_pb(input logic [3:0] m);
    {pb4, pb3, pb2, pb1} = m;
  endtask

  task automatic press(input int idx, input logic [3:0] yv, input int hold, input int gap);
    logic [3:0] m;
    m = 4'b0001 << idx;
    y = yv;
    set_pb(m);
    cycles(hold);
    set_pb(4'b0000);
    cycles(gap);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n = 1'b1; y = '0; set_pb(4'b0000); operands_ack = 1'b0;
    #1 rst_n = 1'b0;
    model_reset();
    #1;
    n_checks++;
    if ({a, b, loaded, operands_valid} !== 19'd0)
      $display("FAIL reset_async: got a=%h b=%h loaded=%b valid=%b required all zero", a, b, loaded, operands_valid);
    else n_pass++;
    @(negedge clk);
    cycle();
    rst_n = 1'b1;
    cycles(20);
    n_checks++;
    if ({a, b, loaded, operands_valid} !== 19'd0)
      $display("FAIL reset_idle: got a=%h b=%h loaded=%b valid=%b required all zero", a, b, loaded, operands_valid);
    else n_pass++;
  endtask

  task automatic test_full_load();
    bit seen;
    press(0, 4'b0101, 10, 10);
    press(1, 4'b1011, 10, 10);
    press(2, 4'b0011, 10, 10);
    n_checks++;
    if (loaded !== 4'b0111 || operands_valid !== 1'b0)
      $display("FAIL partial_load: got loaded=%b valid=%b required 0111/0", loaded, operands_valid);
    else n_pass++;
    y = 4'b0110;
    set_pb(4'b1000);
    seen = 0;
    for (int k = 0; k < 20 && !seen; k++) begin
      cycle();
      if (loaded == 4'b1111) seen = 1;
    end
    n_checks++;
    if (!seen || operands_valid !== 1'b0)
      $display("FAIL valid_early: got loaded_seen=%0d valid=%b required 1/0", seen, operands_valid);
    else n_pass++;
    cycle();
    n_checks++;
    if (operands_valid !== 1'b1)
      $display("FAIL valid_next_edge: got %b required 1", operands_valid);
    else n_pass++;
    set_pb(4'b0000);
    cycles(10);
    n_checks++;
    if (a !== 7'h35 || b !== 7'h63 || loaded !== 4'b1111 || operands_valid !== 1'b1)
      $display("FAIL full_load: got a=%h b=%h loaded=%b valid=%b required 35/63/1111/1", a, b, loaded, operands_valid);
    else n_pass++;
    operands_ack = 1'b1;
    cycle();
    operands_ack = 1'b0;
    n_checks++;
    if (a !== 7'h35 || b !== 7'h63 || loaded !== 4'b0000 || operands_valid !== 1'b0)
      $display("FAIL ack_clear: got a=%h b=%h loaded=%b valid=%b required 35/63/0000/0", a, b, loaded, operands_valid);
    else n_pass++;
    operands_ack = 1'b1;
    cycles(3);
    operands_ack = 1'b0;
    n_checks++;
    if (loaded !== 4'b0000 || operands_valid !== 1'b0)
      $display("FAIL ack_idle_ignored: got loaded=%b valid=%b required 0000/0", loaded, operands_valid);
    else n_pass++;
  endtask

  task automatic test_bounce();
    y = 4'b1111;
    for (int k = 0; k < 10; k++) begin
      set_pb(4'b0001); cycles(2);
      set_pb(4'b0000); cycles(2);
    end
    cycles(10);
    n_checks++;
    if (loaded[0] !== 1'b0 || a !== 7'h35)
      $display("FAIL bounce_reject: got loaded=%b a=%h required loaded[0]=0 a=35", loaded, a);
    else n_pass++;
  endtask

  task automatic test_hold();
    y = 4'b0001;
    set_pb(4'b0100);
    cycles(15);
    y = 4'b1111;
    cycles(35);
    n_checks++;
    if (b[3:0] !== 4'b0001 || loaded !== 4'b0100)
      $display("FAIL hold_single: got b=%h loaded=%b required b[3:0]=1 loaded=0100", b, loaded);
    else n_pass++;
    set_pb(4'b0000);
    cycles(10);
  endtask

  task automatic test_collision();
    press(0, 4'b0000, 10, 10);
    press(3, 4'b0000, 10, 10);
    press(1, 4'b0000, 10, 10);
    n_checks++;
    if (operands_valid !== 1'b1 || a !== 7'h00)
      $display("FAIL collision_setup: got valid=%b a=%h required 1/00", operands_valid, a);
    else n_pass++;
    y = 4'b0111;
    set_pb(4'b0010);
    cycles(DC + 3);
    n_checks++;
    if (operands_valid !== 1'b1 || a[6:4] !== 3'b000)
      $display("FAIL collision_pre: got valid=%b a=%h required 1 and a[6:4]=0", operands_valid, a);
    else n_pass++;
    operands_ack = 1'b1;
    cycle();
    operands_ack = 1'b0;
    n_checks++;
    if (a[6:4] !== 3'b111 || loaded !== 4'b0010 || operands_valid !== 1'b0)
      $display("FAIL collision: got a=%h loaded=%b valid=%b required a[6:4]=7 0010/0", a, loaded, operands_valid);
    else n_pass++;
    set_pb(4'b0000);
    cycles(10);
  endtask

  task automatic test_reset_mid_debounce();
    y = 4'b0101;
    set_pb(4'b1000);
    cycles(4);
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    n_checks++;
    if ({a, b, loaded, operands_valid} !== 19'd0)
      $display("FAIL reset_async_loaded: got a=%h b=%h loaded=%b valid=%b required all zero", a, b, loaded, operands_valid);
    else n_pass++;
    @(negedge clk);
    cycle();
    rst_n = 1'b1;
    cycles(20);
    n_checks++;
    if (loaded !== 4'b0000 || b !== 7'h00)
      $display("FAIL held_through_reset: got loaded=%b b=%h required 0000/00", loaded, b);
    else n_pass++;
    set_pb(4'b0000);
    cycles(15);
    set_pb(4'b1000);
    cycles(12);
    n_checks++;
    if (loaded !== 4'b1000 || b !== 7'h50)
      $display("FAIL repress_after_reset: got loaded=%b b=%h required 1000/50", loaded, b);
    else n_pass++;
    set_pb(4'b0000);
    cycles(10);
  endtask

  task automatic test_random();
    logic [3:0] mask;
    int hold, gap;
    for (int ep = 0; ep < 200; ep++) begin
      if ($urandom_range(0, 4) == 0) mask = 4'($urandom);
      else mask = 4'b0001 << $urandom_range(0, 3);
      y    = 4'($urandom);
      hold = $urandom_range(1, 14);
      gap  = $urandom_range(0, 10);
      set_pb(mask);
      for (int c = 0; c < hold + gap; c++) begin
        if (c == hold) set_pb(4'b0000);
        if ($urandom_range(0, 7) == 0) y = 4'($urandom);
        operands_ack = ($urandom_range(0, 5) == 0);
        cycle();
        n_checks++;
        if (a !== m_a) $display("FAIL rand_a: got %h required %h", a, m_a);
        else n_pass++;
        n_checks++;
        if (b !== m_b) $display("FAIL rand_b: got %h required %h", b, m_b);
        else n_pass++;
        n_checks++;
        if (loaded !== m_loaded) $display("FAIL rand_loaded: got %b required %b", loaded, m_loaded);
        else n_pass++;
        n_checks++;
        if (operands_valid !== m_valid) $display("FAIL rand_valid: got %b required %b", operands_valid, m_valid);
        else n_pass++;
      end
    end
    operands_ack = 1'b0;
  endtask

  initial begin
    test_reset();
    test_full_load();
    test_bounce();
    test_hold();
    test_collision();
    test_reset_mid_debounce();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/operand_entry_ctrl.md
Name: operand_entry_ctrl

Overview:
- Front-end stage that feeds the 7-bit ripple-carry adder.
- Synchronises and debounces the four raw operand pushbuttons and the 4-bit switch bus.
- Assembles the two 7-bit operands A and B from nibble loads and presents them to the adder with a valid/ack handshake.
- Drives status LEDs showing which nibbles are loaded.

Parameters:
- DEBOUNCE_CYCLES, 250000: consecutive cycles a synchronised button level must differ from the debounced level before it is accepted (5 ms at 50 MHz).
- CNT_W, 18: debounce counter width. Must satisfy 2^CNT_W > DEBOUNCE_CYCLES.

Ports:
- clk, input, 1: sole clock, rising edge.
- rst_n, input, 1: asynchronous active-low reset.
- y, input, 4: raw switch bus (asynchronous).
- pb1, input, 1: raw button, load A[3:0].
- pb2, input, 1: raw button, load A[6:4].
- pb3, input, 1: raw button, load B[3:0].
- pb4, input, 1: raw button, load B[6:4].
- a, output, 7: operand A to the adder.
- b, output, 7: operand B to the adder.
- operands_valid, output, 1: A and B fully loaded since the last ack.
- operands_ack, input, 1: consumer accepted the operands (synchronous to clk).
- loaded, output, 4: per-nibble loaded flags, bit i corresponds to pb(i+1).

Behaviour:
- Reset (rst_n=0, asynchronous): a=0, b=0, loaded=0, operands_valid=0. All synchronisers, debounced levels, counters and strobes are cleared.
- Reset mid-debounce discards the pending press. A button still held when reset releases must first be seen low, debounced, before a new rise is accepted.
- Synchronisation: y and each pbN pass through a 2-flop synchroniser. Only synchronised values are used internally.
- Debounce (per button, independent):
  - Synced level s, debounced level d, counter cnt.
  - If s==d: cnt<=0.
  - If s!=d: cnt<=cnt+1. When cnt==DEBOUNCE_CYCLES-1, d<=s and cnt<=0.
  - A glitch shorter than DEBOUNCE_CYCLES cycles never changes d.
- Load strobe: a registered one-cycle pulse when d goes 0->1. Release (1->0) produces no strobe. Holding a button produces exactly one strobe.
- Field capture: in the cycle a strobe is high, the field takes the synchronised y:
  - pb1: a[3:0] <= y_s.
  - pb2: a[6:4] <= y_s[2:0] (y[3] ignored).
  - pb3: b[3:0] <= y_s.
  - pb4: b[6:4] <= y_s[2:0] (y[3] ignored).
  - The matching loaded bit is set in the same edge.
- Latency: a clean raw press held steadily is reflected in a/b/loaded DEBOUNCE_CYCLES+3 rising edges after it is first sampled high (+1 edge for asynchronous sampling uncertainty).
- Simultaneous strobes: all of them apply in the same edge, with no priority.
- operands_valid is a registered output: it goes to 1 on the edge after loaded becomes 4'b1111.
- Handshake:
  - operands_valid stays 1 until operands_ack is sampled high while operands_valid is 1.
  - On that edge: loaded<=0 and operands_valid<=0.
  - a and b hold their values; they are never cleared except by reset.
  - operands_ack while operands_valid=0 is ignored.
- Ack and strobe in the same cycle: loaded is cleared, then the strobing bits are set (the new load wins). The field is updated. operands_valid goes to 0.
- Reload while valid: the field updates, operands_valid stays 1, and the adder output follows the new value.
- FSM (implicit in loaded/operands_valid): COLLECT (loaded!=1111) -> READY (valid=1) -> COLLECT on ack.

Optional Feature:
- Macro: DEBOUNCE_BYPASS_EN.
- Defined: debounce counters are removed and d = s directly. Press-to-capture latency is 3 edges. Intended for simulation and fast benches.
- Undefined: full debounce as specified above.
- Handshake, synchronisation and reset behaviour are identical in both builds.

Test Plan:
- 1. Reset: assert rst_n=0 with buttons idle -> a=0, b=0, loaded=0000, operands_valid=0, all asynchronously.
- 2. Full load (DEBOUNCE_CYCLES=4): press pb1 with y=0101, pb2 with y=1011, pb3 with y=0011, pb4 with y=0110, each held 10 cycles -> a=7'h35, b=7'h63, loaded=1111, operands_valid=1 one edge after the last load. Pulse operands_ack -> loaded=0000, valid=0, a/b unchanged.
- 3. Bounce rejection: toggle pb1 every 2 cycles for 20 cycles, then release -> no strobe, loaded[0]=0, a unchanged.
- 4. Hold: keep pb3 high for 50 cycles with y changing 0001->1111 after capture -> exactly one capture, b[3:0]=0001.
- 5. Collision: with valid=1, assert operands_ack in the same cycle as the pb2 strobe (y=0111) -> a[6:4]=111, loaded=0010, operands_valid=0.
- 6. Reset mid-debounce: press pb4, assert rst_n=0 after 2 debounce cycles while still holding, release reset -> no capture until pb4 is released and pressed again.
